// File: rtl/ss_capture_if.sv
// Bus between a multiplexed 4-digit 7-segment driver (master) and ss_capture (slave).
interface ss_capture_if;
    logic [3:0] AN;
    logic [7:0] SEG;
    logic [3:0] hr_u;
    logic [3:0] hr_l;
    logic [3:0] min_u;
    logic [3:0] min_l;
    logic       frame_valid;
    logic       frame_err;
    logic       timeout;

    modport master (
        output AN, SEG,
        input  hr_u, hr_l, min_u, min_l, frame_valid, frame_err, timeout
    );

    modport slave (
        input  AN, SEG,
        output hr_u, hr_l, min_u, min_l, frame_valid, frame_err, timeout
    );
endinterface

// File: rtl/ss_capture.sv
// Samples a scanned 7-segment display, decodes each digit back to BCD and publishes HH:MM frames.
// Optional SS_CAPTURE_CHANGE_ONLY_EN: suppress frames identical to the last published one.
module ss_capture #(
    parameter int unsigned settle_cycles  = 16,
    parameter int unsigned timeout_cycles = 1000000
) (
    input logic         CLK100MHZ,
    input logic         RST,
    ss_capture_if.slave bus
);
    localparam int unsigned SetW = (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
    localparam int unsigned ToW  = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    localparam logic [SetW-1:0] SetLast = SetW'(settle_cycles - 1);
    localparam logic [ToW-1:0]  ToLast  = ToW'(timeout_cycles - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

    // Returns {err, bcd}; unknown patterns decode to 4'hF with err set.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'h40:   return 5'h00;
            7'h79:   return 5'h01;
            7'h24:   return 5'h02;
            7'h30:   return 5'h03;
            7'h19:   return 5'h04;
            7'h12:   return 5'h05;
            7'h02:   return 5'h06;
            7'h78:   return 5'h07;
            7'h00:   return 5'h08;
            7'h10:   return 5'h09;
            default: return 5'h1F;
        endcase
    endfunction

    function automatic logic single_sel(input logic [3:0] an);
        return (an == 4'b0111) || (an == 4'b1011) || (an == 4'b1101) || (an == 4'b1110);
    endfunction

    function automatic logic [1:0] anode_idx(input logic [3:0] an);
        case (an)
            4'b0111: return 2'd3;
            4'b1011: return 2'd2;
            4'b1101: return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    state_e          state_q;
    logic [3:0]      an_q;
    logic [7:0]      seg_q;
    logic [3:0]      an_lat_q;
    logic [7:0]      seg_lat_q;
    logic [SetW-1:0] set_cnt_q;
    logic [ToW-1:0]  to_cnt_q;
    logic [3:0]      mask_q;
    logic [3:0]      err_q;
    logic [3:0]      slot_q [4];
    logic [3:0]      hr_u_q, hr_l_q, min_u_q, min_l_q;
    logic            frame_valid_q, frame_err_q, timeout_q;
`ifdef SS_CAPTURE_CHANGE_ONLY_EN
    logic            pub_seen_q;
`endif

    logic [4:0] dec;
    logic [1:0] lat_idx;
    logic       publish;

    always_comb begin
        dec     = decode_seg(seg_lat_q[6:0]);
        lat_idx = anode_idx(an_lat_q);
`ifdef SS_CAPTURE_CHANGE_ONLY_EN
        publish = !pub_seen_q ||
                  ({slot_q[3], slot_q[2], slot_q[1], slot_q[0], |err_q} !=
                   {hr_u_q, hr_l_q, min_u_q, min_l_q, frame_err_q});
`else
        publish = 1'b1;
`endif
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            state_q       <= StIdle;
            an_q          <= 4'hF;
            seg_q         <= 8'hFF;
            an_lat_q      <= 4'hF;
            seg_lat_q     <= 8'hFF;
            set_cnt_q     <= '0;
            to_cnt_q      <= '0;
            mask_q        <= '0;
            err_q         <= '0;
            for (int i = 0; i < 4; i++) slot_q[i] <= '0;
            hr_u_q        <= '0;
            hr_l_q        <= '0;
            min_u_q       <= '0;
            min_l_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_q     <= 1'b0;
`ifdef SS_CAPTURE_CHANGE_ONLY_EN
            pub_seen_q    <= 1'b0;
`endif
        end else begin
            an_q          <= bus.AN;
            seg_q         <= bus.SEG;
            frame_valid_q <= 1'b0;
            timeout_q     <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (single_sel(an_q)) begin
                        an_lat_q  <= an_q;
                        seg_lat_q <= seg_q;
                        set_cnt_q <= '0;
                        state_q   <= StSettle;
                    end
                end
                StSettle: begin
                    if (!single_sel(an_q)) begin
                        state_q <= StIdle;
                    end else if (an_q != an_lat_q || seg_q != seg_lat_q) begin
                        an_lat_q  <= an_q;
                        seg_lat_q <= seg_q;
                        set_cnt_q <= '0;
                    end else if (set_cnt_q == SetLast) begin
                        slot_q[lat_idx] <= dec[3:0];
                        err_q[lat_idx]  <= dec[4];
                        mask_q[lat_idx] <= 1'b1;
                        state_q         <= StHold;
                    end else begin
                        set_cnt_q <= set_cnt_q + SetW'(1);
                    end
                end
                StHold: begin
                    // One capture per dwell: only an anode change re-arms the settle window.
                    if (an_q != an_lat_q) begin
                        if (single_sel(an_q)) begin
                            an_lat_q  <= an_q;
                            seg_lat_q <= seg_q;
                            set_cnt_q <= '0;
                            state_q   <= StSettle;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (mask_q == '0) to_cnt_q <= '0;
            else              to_cnt_q <= to_cnt_q + ToW'(1);

            // Completion takes precedence over a coincident timeout.
            if (mask_q == 4'hF) begin
                mask_q   <= '0;
                err_q    <= '0;
                to_cnt_q <= '0;
                if (publish) begin
                    hr_u_q        <= slot_q[3];
                    hr_l_q        <= slot_q[2];
                    min_u_q       <= slot_q[1];
                    min_l_q       <= slot_q[0];
                    frame_err_q   <= |err_q;
                    frame_valid_q <= 1'b1;
`ifdef SS_CAPTURE_CHANGE_ONLY_EN
                    pub_seen_q    <= 1'b1;
`endif
                end
            end else if (mask_q != '0 && to_cnt_q == ToLast) begin
                mask_q    <= '0;
                err_q     <= '0;
                to_cnt_q  <= '0;
                timeout_q <= 1'b1;
                state_q   <= StIdle;
            end
        end
    end

    assign bus.hr_u        = hr_u_q;
    assign bus.hr_l        = hr_l_q;
    assign bus.min_u       = min_u_q;
    assign bus.min_l       = min_l_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_ss_capture.sv
// Randomized bench for ss_capture: dwell-level reference model of the capture rules plus directed cases.
module tb_ss_capture;
    localparam int unsigned Settle  = 4;
    localparam int unsigned Timeout = 1200;
    localparam logic [6:0] SegTab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic CLK100MHZ = 1'b0;
    logic RST       = 1'b1;
    always #5 CLK100MHZ = ~CLK100MHZ;

    ss_capture_if bus ();

    ss_capture #(
        .settle_cycles (Settle),
        .timeout_cycles(Timeout)
    ) dut (
        .CLK100MHZ(CLK100MHZ),
        .RST      (RST),
        .bus      (bus)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned n_frames = 0;
    int unsigned n_timeouts = 0;
    logic [16:0] seen_frame = '0;

    // Reference model state: one entry per display position, frames kept as {err, hu, hl, mu, ml}.
    logic [3:0]  m_slot [4];
    logic [3:0]  m_err;
    logic [3:0]  m_mask;
    logic [3:0]  m_prev_an;
    logic        m_prev_cap;
    logic [16:0] m_last;
    logic        m_have_pub;
    int unsigned m_pushed;
    logic        model_en;
    logic [16:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK100MHZ) begin
        if (!RST) begin
            if (bus.frame_valid === 1'b1) begin
                n_frames++;
                seen_frame = {bus.frame_err, bus.hr_u, bus.hr_l, bus.min_u, bus.min_l};
                check_eq("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check_eq("frame_value", 32'(seen_frame), 32'(exp_q.pop_front()));
            end
            if (bus.timeout === 1'b1) n_timeouts++;
        end
    end

    function automatic int sel_index(input logic [3:0] an);
        int zeros = 0;
        int pos = -1;
        for (int i = 0; i < 4; i++) begin
            if (!an[i]) begin
                zeros++;
                pos = i;
            end
        end
        return (zeros == 1) ? pos : -1;
    endfunction

    function automatic logic [7:0] seg_of(input int d);
        logic [6:0] p;
        if (d < 10) p = SegTab[d];
        else        p = 7'h7F;
        return {1'b1, p};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_slot[i] = '0;
        m_err = '0; m_mask = '0; m_prev_an = 4'hF; m_prev_cap = 1'b0;
        m_last = '0; m_have_pub = 1'b0;
        exp_q.delete();
    endtask

    // A dwell captures once if it lasts at least Settle+1 cycles and is not a
    // continuation of an anode dwell that has already been captured.
    task automatic model_seg(input logic [3:0] an, input logic [7:0] seg, input int len);
        int idx;
        int dig;
        logic [16:0] frame;
        idx = sel_index(an);
        if (idx < 0) begin
            m_prev_an = an; m_prev_cap = 1'b0;
            return;
        end
        if (an == m_prev_an && m_prev_cap) return;
        m_prev_an = an;
        m_prev_cap = 1'b0;
        if (len < int'(Settle) + 1) return;
        m_prev_cap = 1'b1;
        dig = 15;
        for (int i = 0; i < 10; i++) if (SegTab[i] == seg[6:0]) dig = i;
        m_slot[idx] = 4'(dig);
        m_err[idx]  = (dig == 15);
        m_mask[idx] = 1'b1;
        if (m_mask == 4'hF) begin
            frame = {|m_err, m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
            m_mask = '0; m_err = '0;
`ifdef SS_CAPTURE_CHANGE_ONLY_EN
            if (m_have_pub && frame == m_last) return;
`endif
            exp_q.push_back(frame);
            m_pushed++;
            m_last = frame;
            m_have_pub = 1'b1;
        end
    endtask

    task automatic drive_seg(input logic [3:0] an, input logic [7:0] seg, input int len);
        if (model_en) model_seg(an, seg, len);
        bus.AN = an;
        bus.SEG = seg;
        repeat (len) begin
            @(posedge CLK100MHZ);
            #1;
        end
    endtask

    task automatic scan4(input int d3, input int d2, input int d1, input int d0,
                         input int dwell, input int gap);
        int d [4];
        d = '{d0, d1, d2, d3};
        for (int p = 3; p >= 0; p--) begin
            logic [3:0] an;
            an = 4'hF;
            an[p] = 1'b0;
            drive_seg(an, seg_of(d[p]), dwell);
            if (gap > 0) drive_seg(4'hF, 8'hFF, gap);
        end
    endtask

    task automatic random_scan();
        for (int p = 3; p >= 0; p--) begin
            logic [3:0] an;
            logic [7:0] seg;
            logic [3:0] r;
            an = 4'hF;
            an[p] = 1'b0;
            if ($urandom_range(0, 9) == 0) seg = {1'($urandom), 7'($urandom)};
            else                           seg = {1'($urandom), SegTab[$urandom_range(0, 9)]};
            if ($urandom_range(0, 9) == 0) begin
                r = 4'hF;
                r[$urandom_range(0, 3)] = 1'b0;
                drive_seg(r, seg_of($urandom_range(0, 9)), $urandom_range(Settle + 3, Settle + 30));
            end
            if ($urandom_range(0, 3) == 0)
                drive_seg(an, seg ^ 8'h01, $urandom_range(1, Settle - 1));
            if ($urandom_range(0, 5) == 0) begin
                r = 4'hF;
                r[$urandom_range(0, 3)] = 1'b0;
                drive_seg(r, seg_of($urandom_range(0, 9)), $urandom_range(1, Settle - 1));
            end
            drive_seg(an, seg, $urandom_range(Settle + 3, Settle + 30));
            if ($urandom_range(0, 1) == 0) begin
                r = 4'($urandom);
                if (sel_index(r) >= 0) r = 4'hF;
                drive_seg(r, 8'($urandom), $urandom_range(1, 20));
            end
        end
    endtask

    initial begin
        int unsigned nf0;
        int unsigned nt0;
        int unsigned to_after;
        m_pushed = 0;
        model_en = 1'b1;
        model_reset();
        bus.AN = 4'hF;
        bus.SEG = 8'hFF;
        repeat (3) @(posedge CLK100MHZ);
        #1;
        check_eq("rst_digits", 32'({bus.hr_u, bus.hr_l, bus.min_u, bus.min_l}), 32'h0);
        check_eq("rst_valid", 32'(bus.frame_valid), 32'd0);
        check_eq("rst_err", 32'(bus.frame_err), 32'd0);
        check_eq("rst_timeout", 32'(bus.timeout), 32'd0);
        RST = 1'b0;

        scan4(1, 2, 3, 4, 250, 0);
        drive_seg(4'hF, 8'hFF, 20);
        check_eq("scan_frames", n_frames, m_pushed);
        check_eq("scan_digits", 32'({bus.hr_u, bus.hr_l, bus.min_u, bus.min_l}), 32'h1234);
        check_eq("scan_seen", 32'(seen_frame), 32'h01234);

        nf0 = n_frames;
        scan4(1, 2, 3, 4, 60, 200);
        drive_seg(4'hF, 8'hFF, 20);
        check_eq("gap_frames", n_frames, m_pushed);
`ifdef SS_CAPTURE_CHANGE_ONLY_EN
        check_eq("gap_dup_frames", n_frames - nf0, 32'd0);
`else
        check_eq("gap_dup_frames", n_frames - nf0, 32'd1);
`endif
        check_eq("gap_digits", 32'({bus.hr_u, bus.hr_l, bus.min_u, bus.min_l}), 32'h1234);

        // Short select on hr_u and a segment glitch on hr_l must not capture.
        drive_seg(4'b0111, seg_of(7), Settle - 1);
        drive_seg(4'hF, 8'hFF, 5);
        drive_seg(4'b1011, seg_of(8), 2);
        drive_seg(4'b1011, seg_of(5), Settle + 10);
        drive_seg(4'b1101, seg_of(3), 50);
        drive_seg(4'b1110, seg_of(4), 50);
        drive_seg(4'b0111, seg_of(9), 50);
        drive_seg(4'hF, 8'hFF, 20);
        check_eq("settle_seen", 32'(seen_frame), 32'h09534);
        check_eq("settle_frames", n_frames, m_pushed);

        scan4(1, 2, 3, 15, 60, 0);
        drive_seg(4'hF, 8'hFF, 20);
        check_eq("blank_seen", 32'(seen_frame), 32'h1123F);

        model_en = 1'b0;
        nf0 = n_frames;
        nt0 = n_timeouts;
        repeat ((Timeout + 200) / 100) begin
            drive_seg(4'b0111, seg_of(1), 50);
            drive_seg(4'b1011, seg_of(2), 50);
        end
        drive_seg(4'hF, 8'hFF, Timeout + 20);
        check_eq("to_pulsed", 32'(n_timeouts > nt0), 32'd1);
        check_eq("to_no_frame", n_frames, nf0);
        check_eq("to_hold_digits", 32'({bus.hr_u, bus.hr_l, bus.min_u, bus.min_l}),
                 32'(m_last[15:0]));
        to_after = n_timeouts;
        m_mask = '0; m_err = '0; m_prev_an = 4'hF; m_prev_cap = 1'b0;
        model_en = 1'b1;

        drive_seg(4'b0111, seg_of(2), 40);
        drive_seg(4'b1011, seg_of(0), 40);
        RST = 1'b1;
        bus.AN = 4'hF;
        bus.SEG = 8'hFF;
        repeat (3) begin
            @(posedge CLK100MHZ);
            #1;
            check_eq("midrst_valid", 32'(bus.frame_valid), 32'd0);
        end
        check_eq("midrst_digits", 32'({bus.hr_u, bus.hr_l, bus.min_u, bus.min_l}), 32'h0);
        check_eq("midrst_timeout", 32'(bus.timeout), 32'd0);
        model_reset();
        RST = 1'b0;
        nf0 = n_frames;
        scan4(5, 6, 7, 8, 60, 0);
        scan4(5, 6, 7, 8, 60, 0);
        drive_seg(4'hF, 8'hFF, 20);
`ifdef SS_CAPTURE_CHANGE_ONLY_EN
        check_eq("twice_frames", n_frames - nf0, 32'd1);
`else
        check_eq("twice_frames", n_frames - nf0, 32'd2);
`endif
        check_eq("twice_digits", 32'({bus.hr_u, bus.hr_l, bus.min_u, bus.min_l}), 32'h5678);

        repeat (25) random_scan();
        drive_seg(4'hF, 8'hFF, 50);
        check_eq("rand_pending", exp_q.size(), 32'd0);
        check_eq("rand_frames", n_frames, m_pushed);
        check_eq("rand_no_timeout", n_timeouts, to_after);
        check_eq("rand_digits", 32'({bus.hr_u, bus.hr_l, bus.min_u, bus.min_l}),
                 32'(m_last[15:0]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ss_capture.md
Name: ss_capture

Overview:
- Receive-side counterpart of the multiplexed 4-digit 7-segment driver.
- Samples the anode-select and segment buses as the driver scans them, decodes each digit's segment pattern back to BCD, and reassembles complete HH:MM frames.
- Used in the on-board self-check path and in benches to read back the displayed time without probing the internal time registers.

Parameters:
- settle_cycles, 16: consecutive cycles a single anode must stay selected, with a stable segment pattern, before its digit is sampled. Minimum 1.
- timeout_cycles, 1000000: cycles allowed to complete a full 4-digit frame before the partial frame is discarded (10 ms at 100 MHz).

Ports:
- CLK100MHZ  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- AN  in  4  anode selects, active-low. AN[3]=hr_u, AN[2]=hr_l, AN[1]=min_u, AN[0]=min_l.
- SEG  in  8  {DP,CG,CF,CE,CD,CC,CB,CA}, active-low.
- hr_u, hr_l, min_u, min_l  out  4 each  last completed frame, BCD.
- frame_valid  out  1  one-cycle pulse when a new frame is published.
- frame_err  out  1  qualified with frame_valid: at least one digit in the frame failed to decode.
- timeout  out  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Reset values:
  - All digit outputs 0; frame_valid, frame_err and timeout 0.
  - Captured-slot mask 0; settle counter 0; timeout counter 0.
  - FSM in IDLE.
- Inputs are registered once before use, so all latencies below are counted from the registered copy.
- Selection:
  - "Single select" means exactly one AN bit is 0.
  - AN = 4'b1111 (PWM blanking) or two or more low bits means "no select".
- FSM states:
  - IDLE: entered on no select. On a single select, latch AN and SEG, clear the settle counter, go to SETTLE.
  - SETTLE:
    - If AN and SEG are unchanged, increment the settle counter.
    - If either changes, re-latch the new values and restart the count (or go to IDLE if now no select).
    - When the counter reaches settle_cycles-1, decode the latched SEG[6:0] into the slot for the selected anode, set that slot's mask bit, and go to HOLD.
  - HOLD: wait until AN differs from the latched value, then go to IDLE (no select) or SETTLE (new single select). A slot is captured at most once per anode dwell.
- Decode table (SEG[6:0], active-low):
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
  - Any other pattern stores 4'hF and sets that slot's error bit.
  - DP is ignored.
- Frame completion:
  - On the cycle the fourth mask bit becomes set, the next cycle drives all four digit outputs from the slots and pulses frame_valid.
  - frame_err is the OR of the slot error bits.
  - Mask and error bits are cleared in the same cycle.
  - Capture latency: settle_cycles+2 cycles from a stable select to slot write.
- Recapture: if an anode is captured again before the frame completes, its slot is overwritten; the mask bit stays set.
- Timeout:
  - The counter increments while the mask is nonzero and resets to 0 at frame completion.
  - At timeout_cycles-1: clear mask and error bits, pulse timeout, and return the FSM to IDLE.
  - Digit outputs keep the last completed frame.
- If frame completion and timeout occur in the same cycle, completion wins and no timeout pulse is issued.
- RST asserted mid-capture: all state returns to reset values on the next edge, and no pulse is emitted.

Optional Feature:
- SS_CAPTURE_CHANGE_ONLY_EN:
  - Defined: a completed frame that is identical (digits and frame_err) to the last published frame updates nothing and does not pulse frame_valid. The first frame after reset is always published.
  - Undefined: every completed frame is published.

Test Plan:
- Scan 1,2,3,4 (AN 0111/1011/1101/1110, SEG 0x79/0x24/0x30/0x19), 1000 cycles each -> after 4th capture, frame_valid pulses once with hr_u=1, hr_l=2, min_u=3, min_l=4, frame_err=0.
- Same scan with 200-cycle AN=1111 gaps between digits -> identical frame; the gaps cause no captures.
- Select held only settle_cycles-1 cycles, and segment glitch mid-settle -> no slot written; the count restarts on the glitch.
- Digit min_l shows 0x7F (blank) -> frame_valid with min_l=4'hF, frame_err=1.
- Only AN[3] and AN[2] scanned for timeout_cycles -> timeout pulse, no frame_valid, outputs keep previous frame.
- Two identical scans with SS_CAPTURE_CHANGE_ONLY_EN defined -> one frame_valid. Without the macro -> two. RST mid-scan -> no pulse, outputs 0.
